// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file access sequencer.
// Command struct widths follow the default DATA_W/ADDR_W below.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_id_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The priority pointer flips to the other side
// after every grant; grants are only issued while enabled.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_valid_a,
    input  logic i_valid_b,
    output logic o_grant_a,
    output logic o_grant_b
);

    req_id_e r_ptr;

    always_comb begin
        o_grant_a = 1'b0;
        o_grant_b = 1'b0;
        if (i_en) begin
            if (i_valid_a && i_valid_b) begin
                o_grant_a = (r_ptr == REQ_A);
                o_grant_b = (r_ptr == REQ_B);
            end else begin
                o_grant_a = i_valid_a;
                o_grant_b = i_valid_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= REQ_A;
        end else if (o_grant_a) begin
            r_ptr <= other_req(REQ_A);
        end else if (o_grant_b) begin
            r_ptr <= other_req(REQ_B);
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrates two requesters onto the register file ports and sequences the
// level-sensitive write strobe (setup, one-cycle enable, hold).
//
// state     | meaning
// IDLE      | arbitrate, accept one command
// RD        | read address presented, data captured at end of cycle
// WR_SETUP  | write address/data stable, enable low
// WR_STROBE | write enable high for one cycle
// WR_HOLD   | enable low, address/data held, response issued next
module regfile_access_ctrl #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_write,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_write,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              busy
);
    import regfile_pkg::*;

    state_e            r_state;
    state_e            w_state_nxt;
    cmd_t              r_cmd;
    cmd_t              w_cmd_in;
    req_id_e           r_owner;
    logic              r_we;
    logic              w_arb_en;
    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_rsp_data;
    logic              r_a_rsp_valid;
    logic              r_b_rsp_valid;
    logic [DATA_W-1:0] r_a_rsp_data;
    logic [DATA_W-1:0] r_b_rsp_data;

    // Gating with reset keeps both readies low while reset is held.
    assign w_arb_en = (r_state == IDLE) && !reset;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_en      (w_arb_en),
        .i_valid_a (a_req_valid),
        .i_valid_b (b_req_valid),
        .o_grant_a (w_grant_a),
        .o_grant_b (w_grant_b)
    );

    assign a_req_ready = w_grant_a;
    assign b_req_ready = w_grant_b;
    assign w_accept    = w_grant_a | w_grant_b;

    always_comb begin
        w_cmd_in       = '0;
        w_cmd_in.write = a_req_write;
        w_cmd_in.addr  = a_req_addr;
        w_cmd_in.wdata = a_req_wdata;
        if (w_grant_b) begin
            w_cmd_in.write = b_req_write;
            w_cmd_in.addr  = b_req_addr;
            w_cmd_in.wdata = b_req_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_cmd_in.write ? WR_SETUP : RD;
                end
            end
            RD:        w_state_nxt = IDLE;
            WR_SETUP:  w_state_nxt = WR_STROBE;
            WR_STROBE: w_state_nxt = WR_HOLD;
            WR_HOLD:   w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Enable comes straight from a flop so the register file never sees a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= (w_state_nxt == WR_STROBE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd   <= '0;
            r_owner <= REQ_A;
        end else if (w_accept) begin
            r_cmd   <= w_cmd_in;
            r_owner <= w_grant_b ? REQ_B : REQ_A;
        end
    end

    assign w_rsp_fire = (r_state == RD) || (r_state == WR_HOLD);
    assign w_rsp_data = r_cmd.write ? r_cmd.wdata : rf_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            r_a_rsp_data  <= '0;
            r_b_rsp_data  <= '0;
        end else begin
            r_a_rsp_valid <= w_rsp_fire && (r_owner == REQ_A);
            r_b_rsp_valid <= w_rsp_fire && (r_owner == REQ_B);
            if (w_rsp_fire && (r_owner == REQ_A)) begin
                r_a_rsp_data <= w_rsp_data;
            end
            if (w_rsp_fire && (r_owner == REQ_B)) begin
                r_b_rsp_data <= w_rsp_data;
            end
        end
    end

    assign a_rsp_valid     = r_a_rsp_valid;
    assign a_rsp_data      = r_a_rsp_data;
    assign b_rsp_valid     = r_b_rsp_valid;
    assign b_rsp_data      = r_b_rsp_data;
    assign rf_write_addr   = r_cmd.addr;
    assign rf_write_data   = r_cmd.wdata;
    assign rf_write_enable = r_we;
    assign rf_read_addr    = r_cmd.addr;
    assign busy            = (r_state != IDLE);

endmodule
